// File: rtl/poly_cmd_sequencer.sv
// Command sequencer: decodes STP/EVP/EVB/RST tokens, streams coefficients into RAM or x values through the evaluator.
// Latency: STP of degree d spans 3+2(d+1)+1 cycles inclusive from cmd_rd_en to status_wr_en when FIFOs are ready.
// Backpressure: stalls in DATA_RD on an empty data FIFO, in RESULT/STATUS on a full result/status FIFO; one FIFO op per cycle.
module poly_cmd_sequencer #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int num_vectors = 8,
  parameter int max_degree  = 10,
  localparam int PW  = $clog2(buffer_size) + 1,
  localparam int VW  = $clog2(num_vectors),
  localparam int DW  = $clog2(max_degree + 1),
  localparam int CAW = $clog2(num_vectors * (max_degree + 1))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PW-1:0]        cmd_population,
  output logic                 cmd_rd_en,
  input  logic [word_size-1:0] cmd_data,
  input  logic [PW-1:0]        data_population,
  output logic                 data_rd_en,
  input  logic [word_size-1:0] data_in,
  input  logic [PW-1:0]        result_free_space,
  output logic                 result_wr_en,
  output logic [word_size-1:0] result_data,
  input  logic [PW-1:0]        status_free_space,
  output logic                 status_wr_en,
  output logic [word_size-1:0] status_data,
  output logic                 c_ram_wr_en,
  output logic [CAW-1:0]       c_ram_addr,
  output logic [word_size-1:0] c_ram_wdata,
  output logic                 eval_start,
  output logic [VW-1:0]        eval_vec,
  output logic [DW-1:0]        eval_degree,
  output logic [word_size-1:0] eval_x,
  input  logic                 eval_done,
  input  logic [word_size-1:0] eval_result,
  output logic                 busy
);

  localparam int AW = word_size - 8;
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_STP = 2'd0;
  localparam logic [1:0] OP_EVP = 2'd1;
  localparam logic [1:0] OP_EVB = 2'd2;
  localparam logic [1:0] OP_RST = 2'd3;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CMD_WAIT  = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_DATA_RD   = 4'd3;
  localparam logic [3:0] S_DATA_WAIT = 4'd4;
  localparam logic [3:0] S_EVAL      = 4'd5;
  localparam logic [3:0] S_EVAL_WAIT = 4'd6;
  localparam logic [3:0] S_RESULT    = 4'd7;
  localparam logic [3:0] S_STATUS    = 4'd8;

  localparam logic [CAW-1:0] STRIDE = CAW'(max_degree + 1);

  logic [3:0]             state_q, state_d;
  logic                   arm_q;
  logic [1:0]             op_q, code_q;
  logic [5:0]             vec_q;
  logic [AW-1:0]          arg_q;
  logic [CW-1:0]          cnt_q;
  logic [DW-1:0]          idx_q;
  logic [DW-1:0]          degree_q [num_vectors];
  logic [num_vectors-1:0] valid_q;
  logic                   eval_start_q;
  logic [VW-1:0]          eval_vec_q;
  logic [DW-1:0]          eval_degree_q;
  logic [word_size-1:0]   eval_x_q, result_q;

  logic [VW-1:0] vsel;
  logic          vec_bad, arg_bad, last;
  logic [1:0]    dec_code;
  logic          dec_go;

  assign vsel    = vec_q[VW-1:0];
  // vec is a 6-bit field, so out-of-range vectors must be caught before indexing the table
  assign vec_bad = 32'(vec_q) >= num_vectors;
  assign arg_bad = 32'(arg_q) > max_degree;
  assign last    = (cnt_q == CW'(1));

  // Decode priority: bad vector, bad degree, unloaded vector, then the no-data successes
  always_comb begin
    dec_code = 2'd0;
    dec_go   = 1'b0;
    if (vec_bad)                                               dec_code = 2'd1;
    else if (op_q == OP_STP && arg_bad)                        dec_code = 2'd2;
    else if ((op_q == OP_EVP || op_q == OP_EVB) && !valid_q[vsel]) dec_code = 2'd3;
    else if (op_q == OP_RST || (op_q == OP_EVB && arg_q == '0)) dec_code = 2'd0;
    else                                                       dec_go   = 1'b1;
  end

  // Next-state logic and the FIFO strobes, each gated by its occupancy/free-space input
  always_comb begin
    state_d      = state_q;
    cmd_rd_en    = 1'b0;
    data_rd_en   = 1'b0;
    result_wr_en = 1'b0;
    status_wr_en = 1'b0;
    case (state_q)
      S_IDLE: if (arm_q && cmd_population != '0) begin
        cmd_rd_en = 1'b1;
        state_d   = S_CMD_WAIT;
      end
      S_CMD_WAIT: state_d = S_DECODE;
      S_DECODE:   state_d = dec_go ? S_DATA_RD : S_STATUS;
      S_DATA_RD: if (data_population != '0) begin
        data_rd_en = 1'b1;
        state_d    = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        if (op_q == OP_STP) state_d = last ? S_STATUS : S_DATA_RD;
        else                state_d = S_EVAL;
      end
      S_EVAL:      state_d = S_EVAL_WAIT;
      S_EVAL_WAIT: if (eval_done) state_d = S_RESULT;
      S_RESULT: if (result_free_space != '0) begin
        result_wr_en = 1'b1;
        state_d      = last ? S_STATUS : S_DATA_RD;
      end
      S_STATUS: if (status_free_space != '0) begin
        status_wr_en = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Coefficient writes happen in DATA_WAIT, the cycle the popped token is on data_in
  assign c_ram_wr_en = (state_q == S_DATA_WAIT) && (op_q == OP_STP);
  assign c_ram_addr  = c_ram_wr_en ? (CAW'(vsel) * STRIDE + CAW'(idx_q)) : '0;
  assign c_ram_wdata = c_ram_wr_en ? data_in : '0;

  assign eval_start  = eval_start_q;
  assign eval_vec    = eval_vec_q;
  assign eval_degree = eval_degree_q;
  assign eval_x      = eval_x_q;
  assign result_data = result_q;
  assign status_data = {{(word_size-4){1'b0}}, op_q, code_q};
  assign busy        = (state_q != S_IDLE);

  // State, command fields, counters, degree/valid table and evaluator interface registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      arm_q         <= 1'b0;
      op_q          <= '0;
      code_q        <= '0;
      vec_q         <= '0;
      arg_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      valid_q       <= '0;
      eval_start_q  <= 1'b0;
      eval_vec_q    <= '0;
      eval_degree_q <= '0;
      eval_x_q      <= '0;
      result_q      <= '0;
      for (int i = 0; i < num_vectors; i++) degree_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      // keeps cmd_rd_en low for the first cycle out of reset
      arm_q        <= 1'b1;
      eval_start_q <= 1'b0;
      case (state_q)
        S_CMD_WAIT: begin
          op_q  <= cmd_data[1:0];
          vec_q <= cmd_data[7:2];
          arg_q <= cmd_data[word_size-1:8];
        end
        S_DECODE: begin
          code_q <= dec_code;
          idx_q  <= '0;
          if (dec_go) begin
            eval_vec_q    <= vsel;
            eval_degree_q <= degree_q[vsel];
            if (op_q == OP_STP)      cnt_q <= CW'(arg_q) + CW'(1);
            else if (op_q == OP_EVB) cnt_q <= CW'(arg_q);
            else                     cnt_q <= CW'(1);
          end
          if (op_q == OP_RST && !vec_bad) begin
            valid_q <= '0;
            for (int i = 0; i < num_vectors; i++) degree_q[i] <= '0;
          end
        end
        S_DATA_WAIT: begin
          if (op_q == OP_STP) begin
            cnt_q <= cnt_q - CW'(1);
            if (last) begin
              degree_q[vsel] <= DW'(arg_q);
              valid_q[vsel]  <= 1'b1;
            end else begin
              // idx only advances while more coefficients follow, so it never passes max_degree
              idx_q <= idx_q + DW'(1);
            end
          end else begin
            eval_x_q     <= data_in;
            eval_start_q <= 1'b1;
          end
        end
        S_EVAL_WAIT: if (eval_done) result_q <= eval_result;
        S_RESULT:    if (result_free_space != '0) cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/poly_cmd_sequencer.md
Name: poly_cmd_sequencer

Overview:
- Parametrised command sequencer for the polynomial evaluation accelerator.
- Pops command tokens from the command FIFO and decodes the STP, EVP, EVB and RST instructions.
- Moves coefficient and x tokens from the data FIFO into coefficient RAM or to the evaluator datapath.
- Pushes evaluator results to the result FIFO and exactly one status token per command to the status FIFO.
- Owns a per-vector degree/valid table. Sits between the FIFO boundary and the evaluator core.

Parameters:
- word_size, 16, token and data width (minimum 12).
- buffer_size, 1024, FIFO depth. PW = clog2(buffer_size)+1 is the population/free-space width.
- num_vectors, 8, number of polynomials held. Range 2..64. VW = clog2(num_vectors).
- max_degree, 10, maximum polynomial degree. DW = clog2(max_degree+1). CAW = clog2(num_vectors*(max_degree+1)).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_population  in  PW  command FIFO occupancy
- cmd_rd_en  out  1  command FIFO pop
- cmd_data  in  word_size  command token, valid the cycle after cmd_rd_en
- data_population  in  PW  data FIFO occupancy
- data_rd_en  out  1  data FIFO pop
- data_in  in  word_size  data token, valid the cycle after data_rd_en
- result_free_space  in  PW  result FIFO free slots
- result_wr_en  out  1  result FIFO push
- result_data  out  word_size  result token
- status_free_space  in  PW  status FIFO free slots
- status_wr_en  out  1  status FIFO push
- status_data  out  word_size  status token
- c_ram_wr_en  out  1  coefficient RAM write strobe
- c_ram_addr  out  CAW  coefficient address = vec*(max_degree+1)+i
- c_ram_wdata  out  word_size  coefficient value
- eval_start  out  1  one-cycle evaluator start pulse
- eval_vec  out  VW  vector to evaluate
- eval_degree  out  DW  degree of that vector
- eval_x  out  word_size  x operand
- eval_done  in  1  evaluator completion pulse
- eval_result  in  word_size  result, valid with eval_done
- busy  out  1  high in every state other than IDLE

Behaviour:
- Command token fields:
  - op = [1:0]: STP=0, EVP=1, EVB=2, RST=3.
  - vec = [7:2]
  - arg = [word_size-1:8]
- Reset clears all of the following: every output to 0, the state register to IDLE, all counters, every entry of the degree table and every valid bit.
- Reset mid-command abandons the command. No status token is written for it.
- States and transitions:
  - IDLE: if cmd_population>0, assert cmd_rd_en for one cycle, then go to CMD_WAIT.
  - CMD_WAIT: latch op, vec and arg, then go to DECODE.
  - DECODE: select the status code and path:
    - vec>=num_vectors gives code 1 and goes to STATUS.
    - STP with arg>max_degree gives code 2 and goes to STATUS.
    - EVP or EVB on a vector whose valid bit is 0 gives code 3 and goes to STATUS.
    - EVB with arg==0 gives code 0 and goes to STATUS.
    - RST clears every valid bit and degree entry, gives code 0 and goes to STATUS.
    - Otherwise load cnt with the STP coefficient count (arg+1), the EVB point count (arg) or 1 for EVP, then go to DATA_RD.
  - DATA_RD: wait while data_population==0. Then pulse data_rd_en and go to DATA_WAIT.
  - DATA_WAIT:
    - STP: drive c_ram_wr_en for one cycle with c_ram_addr = vec*(max_degree+1)+idx and c_ram_wdata = data_in. Increment idx and decrement cnt. If cnt reaches 0, write degree[vec]=arg, set valid[vec]=1, give code 0 and go to STATUS. Otherwise go to DATA_RD.
    - EVP/EVB: latch eval_x = data_in and go to EVAL.
  - EVAL: pulse eval_start with eval_vec and eval_degree held stable, then go to EVAL_WAIT.
  - EVAL_WAIT: hold until eval_done. Latch eval_result and go to RESULT.
  - RESULT: wait while result_free_space==0. Then pulse result_wr_en and decrement cnt. If cnt is nonzero go to DATA_RD. Otherwise give code 0 and go to STATUS.
  - STATUS: wait while status_free_space==0. Then pulse status_wr_en with status_data = {zero-pad, op[1:0], code[1:0]} and go to IDLE.
- Error commands (codes 1, 2, 3) consume no data tokens.
- At most one FIFO pop or push is issued per cycle. rd_en is never asserted when the matching population is 0. wr_en is never asserted when the matching free space is 0.
- idx counts 0..max_degree and never wraps. All address arithmetic is unsigned and CAW bits wide.
- eval_done arriving outside EVAL_WAIT is ignored.
- Latency: an STP of degree d with both FIFOs non-empty takes 3 + 2(d+1) + 1 cycles from cmd_rd_en to status_wr_en.

Test Plan:
- STP vec=2 arg=3, data tokens 0x11, 0x22, 0x33, 0x44 -> four c_ram writes at addresses 22..25 carrying 0x11..0x44, then status 0x0000. degree[2]=3, valid[2]=1.
- After that STP, EVP vec=2 with x=5 and the evaluator returning 0x1234 -> eval_start pulses with eval_degree=3 and eval_x=5, result token 0x1234, status 0x0004.
- EVB vec=2 arg=3 with x=1, 2, 3 -> three eval_start/result pairs in order, then one status token 0x0008.
- STP arg=11 -> status 0x0002, data_rd_en never asserted. EVP on vec=9 -> status 0x0005. RST then EVP vec=2 -> statuses 0x000C then 0x0007.
- Backpressure: hold result_free_space=0 for 20 cycles during an EVP -> result_wr_en stays low and busy stays high, and the result is written on the first cycle free space becomes nonzero. data_population=0 stalls the sequencer in DATA_RD.
- Assert rst low midway through an STP of degree 5 -> all outputs go to 0 immediately, valid[vec]=0, and no status token is written. A subsequent STP completes normally.
